program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one parameter: MAX_WORDS, default 1024, the largest program length in words that is accepted.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  synchronous reset; asserted when 1 (active-high despite the name).
- start  in  1  one-cycle request to begin a load.
- in_data  in  8  host byte stream.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_wr  out  1  one-cycle memory write strobe.
- endereco_ext  out  16  write address.
- iin  out  16  write data (instruction word).
- cpu_hold  out  1  keeps the processor from running while 1.
- done  out  1  load completed successfully.
- err  out  1  length was rejected.

Function
REQ-004 A byte SHALL be transferred only in a cycle where in_valid=1 and in_ready=1; in_data is ignored in all other cycles.
REQ-005 The FSM SHALL have the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE and ERROR.
REQ-006 Stream format: 16-bit word count N (high byte first), then N words (high byte first).
REQ-007 The start input SHALL have the following effect per state:
- In IDLE, DONE or ERROR, start=1 SHALL go to LEN_HI, clear done and err, set cpu_hold=1, and zero the word index.
- In all other states, start SHALL be ignored.
REQ-008 in_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-009 The length states SHALL behave as follows:
- A transfer in LEN_HI SHALL store N[15:8] and go to LEN_LO.
- A transfer in LEN_LO SHALL store N[7:0]; the next state is chosen by REQ-010.
REQ-010 Exit from LEN_LO SHALL be decided by N:
- N=0: go to DONE.
- N>MAX_WORDS: go to ERROR.
- Otherwise: go to DATA_HI.
REQ-011 The data states SHALL behave as follows:
- DATA_HI: a transfer stores word[15:8] and goes to DATA_LO.
- DATA_LO: a transfer stores word[7:0] and goes to WRITE.
REQ-012 WRITE SHALL last exactly one cycle, with mem_wr=1, endereco_ext=index and iin=word, all stable for that cycle.
REQ-013 On leaving WRITE, index SHALL increment; if the new index equals N, go to DONE, else go to DATA_HI.
REQ-014 Write latency: mem_wr SHALL be asserted in the cycle immediately after the DATA_LO transfer.
REQ-015 Outside WRITE, mem_wr SHALL be 0; endereco_ext and iin SHALL hold their last values.
REQ-016 DONE SHALL drive done=1 and cpu_hold=0, and hold them until the next start or reset.
REQ-017 ERROR SHALL drive err=1 and cpu_hold=1, with no writes, until the next start or reset.
REQ-018 Index and length arithmetic SHALL be 16-bit unsigned; the index never wraps, because N≤MAX_WORDS≤65535.
REQ-019 Stalls (in_valid=0) in any byte state SHALL hold the state indefinitely, with no timeout.

Reset
REQ-020 With resetn=1 at a clock edge, the next state SHALL be IDLE and the outputs SHALL be in_ready=0, mem_wr=0, endereco_ext=0, iin=0, cpu_hold=0, done=0, err=0; N, index and word SHALL be cleared.
REQ-021 A reset in mid-load SHALL abort the load with no further mem_wr; words already written are not undone, and start is required to reload.
REQ-022 Reset SHALL take priority over start and over any byte transfer in the same cycle.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding and the default MAX_WORDS constant.
REQ-024 A single sub-module, byte_pair_assembler, SHALL be used: it packs high/low bytes into a 16-bit register under hi/lo load enables, and serves both N and the data words.

Verification
REQ-025 Normal load: start; bytes 00 02 A3 FD A4 01 with in_valid held at 1 -> mem_wr pulses twice (addr 0000 data A3FD, then addr 0001 data A401), done=1, cpu_hold=0 after the second write.
REQ-026 Zero length: start; bytes 00 00 -> no mem_wr, done=1 the cycle after the second byte.
REQ-027 Oversize: MAX_WORDS=1024; start; bytes 04 01 -> err=1, cpu_hold=1, in_ready=0, no mem_wr.
REQ-028 Stalls: the REQ-025 stream with in_valid=0 for 5 cycles between every byte -> identical writes, each mem_wr lasting exactly one cycle.
REQ-029 Reset mid-load: assert resetn for one cycle after byte A3 -> all outputs at reset values, no further writes; a fresh start plus the full stream then completes normally.
REQ-030 Start ignored: a start pulse while in DATA_LO -> no state change, and the load completes as in REQ-025.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader FSM state encoding and default program size limit.
package program_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR} state_t;
  localparam int MAX_WORDS_DEFAULT = 1024;
endpackage

// File: rtl/byte_pair_assembler.sv
// byte_pair_assembler: packs a high and a low byte into one 16-bit register.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_ld,
  input  logic        lo_ld,
  input  logic [7:0]  byte_in,
  output logic [15:0] word
);
  always_ff @(posedge clk)
    if (rst) word <= '0;
    else begin
      if (hi_ld) word[15:8] <= byte_in;
      if (lo_ld) word[7:0] <= byte_in;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program from a byte host into instruction memory.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_wr,
  output logic [15:0] endereco_ext,
  output logic [15:0] iin,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
  state_t state, state_nx;
  logic [15:0] len, word, idx, len_full;
  logic xfer, go;
  assign xfer = in_valid && in_ready;
  assign go = start && (state inside {IDLE, DONE, ERROR});
  assign len_full = {len[15:8], in_data};
  byte_pair_assembler u_len (
    .clk(clock), .rst(resetn), .hi_ld(xfer && state == LEN_HI), .lo_ld(xfer && state == LEN_LO),
    .byte_in(in_data), .word(len)
  );
  byte_pair_assembler u_word (
    .clk(clock), .rst(resetn), .hi_ld(xfer && state == DATA_HI), .lo_ld(xfer && state == DATA_LO),
    .byte_in(in_data), .word(word)
  );
  always_comb begin
    state_nx = state;
    in_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
    mem_wr = state == WRITE;
    cpu_hold = !(state inside {IDLE, DONE});
    done = state == DONE;
    err = state == ERROR;
    case (state)
      IDLE, DONE, ERROR: state_nx = start ? LEN_HI : state;
      LEN_HI:  state_nx = xfer ? LEN_LO : state;
      LEN_LO:  state_nx = !xfer ? state : len_full == '0 ? DONE : len_full > MAX_N ? ERROR : DATA_HI;
      DATA_HI: state_nx = xfer ? DATA_LO : state;
      DATA_LO: state_nx = xfer ? WRITE : state;
      WRITE:   state_nx = idx + 16'd1 == len ? DONE : DATA_HI;
      default: state_nx = IDLE;
    endcase
  end
  // address/data are captured with the low byte so they stay frozen after the strobe
  always_ff @(posedge clock)
    if (resetn) begin
      state <= IDLE;
      idx <= '0;
      endereco_ext <= '0;
      iin <= '0;
    end else begin
      state <= state_nx;
      if (go) idx <= '0;
      else if (state == WRITE) idx <= idx + 16'd1;
      if (xfer && state == DATA_LO) begin
        endereco_ext <= idx;
        iin <= {word[15:8], in_data};
      end
    end
endmodule
